tg_mig_responder: RTL and testbench

//  Responder side of the traffic-gen command interface: accepts cmd_vld/cmd_proc/addr/data/blen from an initiator,

---
 rtl/tg_mig_pkg.sv | 42 ++++
 rtl/tg_lane_sel.sv | 29 ++
 rtl/tg_mig_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_tg_mig_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tg_mig_pkg.sv
// Shared definitions for the traffic-gen MIG responder: one-hot state codes,
// MIG command codes, lane geometry and the read-timeout filler word.
package tg_mig_pkg;

    localparam logic [7:0] TG_INIT    = 8'h01;
    localparam logic [7:0] TG_IDLE    = 8'h02;
    localparam logic [7:0] TG_WR      = 8'h04;
    localparam logic [7:0] TG_RD_CMD  = 8'h20;
    localparam logic [7:0] TG_RD_DATA = 8'h40;
    localparam logic [7:0] TG_DONE    = 8'h80;

    typedef enum logic [7:0] {
        ST_INIT    = TG_INIT,
        ST_IDLE    = TG_IDLE,
        ST_WR      = TG_WR,
        ST_RD_CMD  = TG_RD_CMD,
        ST_RD_DATA = TG_RD_DATA,
        ST_DONE    = TG_DONE
    } tg_state_e;

    localparam logic [2:0]  CMD_WR          = 3'b000;
    localparam logic [2:0]  CMD_RD          = 3'b001;
    localparam logic [31:0] RD_TIMEOUT_WORD = 32'hDEADBEEF;

    localparam int WORD_W      = 32;
    localparam int LANES       = 4;
    localparam int LANE_DATA_W = WORD_W * LANES;

    // Byte-disable mask for a 128-bit beat: only the selected 32-bit lane is written
    function automatic logic [15:0] lane_mask(input logic [1:0] lane);
        logic [15:0] m;
        case (lane)
            2'd0:    m = 16'hFFF0;
            2'd1:    m = 16'hFF0F;
            2'd2:    m = 16'hF0FF;
            2'd3:    m = 16'h0FFF;
            default: m = 16'hFFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tg_lane_sel.sv
// Combinational 32<->128 lane steering: write-word replication with lane mask,
// and read-lane extraction from a MIG beat.
module tg_lane_sel
    import tg_mig_pkg::*;
(
    input  logic [1:0]               wr_lane_i,
    input  logic [WORD_W-1:0]        wr_word_i,
    input  logic [1:0]               rd_lane_i,
    input  logic [LANE_DATA_W-1:0]   rd_data_i,
    output logic [LANE_DATA_W-1:0]   wr_data_o,
    output logic [LANE_DATA_W/8-1:0] wr_mask_o,
    output logic [WORD_W-1:0]        rd_word_o
);

    assign wr_data_o = {LANES{wr_word_i}};
    assign wr_mask_o = lane_mask(wr_lane_i);

    // Pick the addressed 32-bit lane out of the returned beat
    always_comb begin
        case (rd_lane_i)
            2'd0:    rd_word_o = rd_data_i[31:0];
            2'd1:    rd_word_o = rd_data_i[63:32];
            2'd2:    rd_word_o = rd_data_i[95:64];
            2'd3:    rd_word_o = rd_data_i[127:96];
            default: rd_word_o = rd_data_i[31:0];
        endcase
    end

endmodule

// File: rtl/tg_mig_responder.sv
// Traffic-gen command responder driving the MIG 7-series app interface with 32-bit word accesses.
// Optional read-data watchdog enabled by defining TG_RD_TIMEOUT_EN.
module tg_mig_responder
    import tg_mig_pkg::*;
#(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_vld,
    input  logic                        cmd_proc,
    input  logic [31:0]                 addr_proc,
    input  logic [31:0]                 data_proc_o,
    input  logic [7:0]                  blen_proc,
    output logic [7:0]                  tg_state,
    output logic                        cmd_cmptd,
    output logic [31:0]                 data_proc_i,
    output logic                        rdata_sig_vld,
    output logic                        err_timeout,
    input  logic                        init_calib_complete,
    output logic [APP_ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]                  app_cmd,
    output logic                        app_en,
    input  logic                        app_rdy,
    output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    input  logic                        app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
    input  logic                        app_rd_data_valid
);

    tg_state_e                   state_q, state_d;
    logic                        app_en_q, app_en_d;
    logic                        wren_q, wren_d;
    logic [2:0]                  app_cmd_q, app_cmd_d;
    logic [31:0]                 addr_q, addr_d;
    logic [7:0]                  blen_q, blen_d;
    logic [7:0]                  beat_q, beat_d;
    logic [APP_DATA_WIDTH-1:0]   wdf_data_q, wdf_data_d;
    logic [APP_DATA_WIDTH/8-1:0] mask_q, mask_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic                        rvld_q, rvld_d;
    logic                        cmptd_q, cmptd_d;

    logic [APP_DATA_WIDTH-1:0]   lane_wdata_s;
    logic [APP_DATA_WIDTH/8-1:0] lane_mask_s;
    logic [31:0]                 lane_rword_s;
    logic                        to_hit_s;
    logic                        addr_unused_s;

    tg_lane_sel u_lane_sel (
        .wr_lane_i (addr_proc[3:2]),
        .wr_word_i (data_proc_o),
        .rd_lane_i (addr_q[3:2]),
        .rd_data_i (app_rd_data),
        .wr_data_o (lane_wdata_s),
        .wr_mask_o (lane_mask_s),
        .rd_word_o (lane_rword_s)
    );

`ifdef TG_RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    assign to_hit_s = (state_q == ST_RD_DATA) && !app_rd_data_valid
                      && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Count RD_DATA cycles spent waiting; restart on every return or state change
    always_comb begin
        err_d = err_q | to_hit_s;
        if ((state_q == ST_RD_DATA) && !app_rd_data_valid && !to_hit_s) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = {TO_W{1'b0}};
        end
    end

    // Watchdog counter and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= {TO_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

    assign to_hit_s    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next state, handshake tracking and next values of every registered output
    always_comb begin
        state_d    = state_q;
        app_en_d   = app_en_q;
        wren_d     = wren_q;
        app_cmd_d  = app_cmd_q;
        addr_d     = addr_q;
        blen_d     = blen_q;
        beat_d     = beat_q;
        wdf_data_d = wdf_data_q;
        mask_d     = mask_q;
        rdata_d    = rdata_q;
        rvld_d     = 1'b0;
        cmptd_d    = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_calib_complete) begin
                    state_d = ST_IDLE;
                    cmptd_d = 1'b1;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (cmd_vld) begin
                    addr_d   = addr_proc;
                    blen_d   = blen_proc;
                    beat_d   = 8'd0;
                    app_en_d = 1'b1;
                    if (cmd_proc) begin
                        state_d    = ST_WR;
                        app_cmd_d  = CMD_WR;
                        wren_d     = 1'b1;
                        wdf_data_d = lane_wdata_s;
                        mask_d     = lane_mask_s;
                    end else begin
                        state_d   = ST_RD_CMD;
                        app_cmd_d = CMD_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                // Command and data channels retire independently
                app_en_d = app_en_q & ~app_rdy;
                wren_d   = wren_q & ~app_wdf_rdy;
                if (!app_en_d && !wren_d) begin
                    state_d = ST_DONE;
                    cmptd_d = 1'b1;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_RD_CMD: begin
                if (app_rdy) begin
                    app_en_d = 1'b0;
                    state_d  = ST_RD_DATA;
                end else begin
                    state_d = ST_RD_CMD;
                end
            end
            ST_RD_DATA: begin
                if (app_rd_data_valid || to_hit_s) begin
                    rvld_d  = 1'b1;
                    rdata_d = app_rd_data_valid ? lane_rword_s : RD_TIMEOUT_WORD;
                    if (beat_q == blen_q) begin
                        state_d = ST_DONE;
                        cmptd_d = 1'b1;
                    end else begin
                        beat_d   = beat_q + 8'd1;
                        addr_d   = addr_q + 32'd4;
                        app_en_d = 1'b1;
                        state_d  = ST_RD_CMD;
                    end
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_INIT;
                app_en_d = 1'b0;
                wren_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            app_en_q   <= 1'b0;
            wren_q     <= 1'b0;
            app_cmd_q  <= 3'b000;
            addr_q     <= 32'h0000_0000;
            blen_q     <= 8'h00;
            beat_q     <= 8'h00;
            wdf_data_q <= {APP_DATA_WIDTH{1'b0}};
            mask_q     <= {(APP_DATA_WIDTH/8){1'b0}};
            rdata_q    <= 32'h0000_0000;
            rvld_q     <= 1'b0;
            cmptd_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            app_en_q   <= app_en_d;
            wren_q     <= wren_d;
            app_cmd_q  <= app_cmd_d;
            addr_q     <= addr_d;
            blen_q     <= blen_d;
            beat_q     <= beat_d;
            wdf_data_q <= wdf_data_d;
            mask_q     <= mask_d;
            rdata_q    <= rdata_d;
            rvld_q     <= rvld_d;
            cmptd_q    <= cmptd_d;
        end
    end

    assign tg_state      = state_q;
    assign cmd_cmptd     = cmptd_q;
    assign data_proc_i   = rdata_q;
    assign rdata_sig_vld = rvld_q;
    assign app_addr      = {addr_q[APP_ADDR_WIDTH:4], 3'b000};
    assign app_cmd       = app_cmd_q;
    assign app_en        = app_en_q;
    assign app_wdf_data  = wdf_data_q;
    assign app_wdf_mask  = mask_q;
    assign app_wdf_wren  = wren_q;
    assign app_wdf_end   = wren_q;
    assign addr_unused_s = ^{addr_q[31:APP_ADDR_WIDTH+1], addr_q[1:0]};

endmodule

// File: tb/tb_tg_mig_responder.sv
// Directed, table-driven bench for tg_mig_responder (write vectors in a table, read/reset/timeout as sequences).
module tb_tg_mig_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_vld, cmd_proc;
    logic [31:0]  addr_proc, data_proc_o;
    logic [7:0]   blen_proc;
    logic [7:0]   tg_state;
    logic         cmd_cmptd;
    logic [31:0]  data_proc_i;
    logic         rdata_sig_vld, err_timeout, init_calib_complete;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;

    tg_mig_responder dut (
        .clk(clk), .reset(reset), .cmd_vld(cmd_vld), .cmd_proc(cmd_proc),
        .addr_proc(addr_proc), .data_proc_o(data_proc_o), .blen_proc(blen_proc),
        .tg_state(tg_state), .cmd_cmptd(cmd_cmptd), .data_proc_i(data_proc_i),
        .rdata_sig_vld(rdata_sig_vld), .err_timeout(err_timeout),
        .init_calib_complete(init_calib_complete), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [27:0] exp_app_addr;
        logic [15:0] exp_mask;
    } wr_vec_t;

    typedef struct {
        logic [27:0] exp_app_addr;
        logic [31:0] exp_word;
    } rd_vec_t;

    wr_vec_t wv[5];
    rd_vec_t rv[4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int en_cnt, wren_cnt, done_cnt, cm_cnt, rv_cnt, nrd, n;
        logic [27:0] aa0, aa2;
        logic [31:0] base_w;
        logic done, got, stuck;

        wv[0] = '{32'h0000_0014, 32'hA5A5_0001, 28'h000_0008, 16'hFF0F};
        wv[1] = '{32'h0000_0000, 32'h1234_5678, 28'h000_0000, 16'hFFF0};
        wv[2] = '{32'h0000_0108, 32'hDEAD_C0DE, 28'h000_0080, 16'hF0FF};
        wv[3] = '{32'hFFFF_FFFC, 32'h0BAD_F00D, 28'hFFF_FFF8, 16'h0FFF};
        wv[4] = '{32'h1000_0010, 32'h7777_0004, 28'h800_0008, 16'hFFF0};
        rv[0] = '{28'h000_0008, 32'hB000_0003};
        rv[1] = '{28'h000_0010, 32'hB000_0010};
        rv[2] = '{28'h000_0010, 32'hB000_0021};
        rv[3] = '{28'h000_0010, 32'hB000_0032};

        reset = 1'b1; cmd_vld = 1'b0; cmd_proc = 1'b0; addr_proc = 32'h0; data_proc_o = 32'h0;
        blen_proc = 8'h0; init_calib_complete = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        app_rd_data = 128'h0; app_rd_data_valid = 1'b0;
        repeat (3) step();

        check("rst_state", tg_state, 8'h01);
        check("rst_app_en", app_en, 1'b0);
        check("rst_wren", app_wdf_wren, 1'b0);
        check("rst_cmptd", cmd_cmptd, 1'b0);
        check("rst_rvld", rdata_sig_vld, 1'b0);
        check("rst_rdata", data_proc_i, 32'h0);
        check("rst_app_addr", app_addr, 28'h0);
        check("rst_mask", app_wdf_mask, 16'h0);
        check("rst_err", err_timeout, 1'b0);

        // Calibration after 50 cycles
        reset = 1'b0;
        en_cnt = 0; cm_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            en_cnt += int'(app_en) + int'(app_wdf_wren);
            cm_cnt += int'(cmd_cmptd);
        end
        check("calib_wait_state", tg_state, 8'h01);
        init_calib_complete = 1'b1;
        step();
        check("calib_idle_state", tg_state, 8'h02);
        check("calib_cmptd", cmd_cmptd, 1'b1);
        cm_cnt += int'(cmd_cmptd);
        for (int i = 0; i < 5; i++) begin
            step();
            en_cnt += int'(app_en) + int'(app_wdf_wren);
            cm_cnt += int'(cmd_cmptd);
        end
        check("calib_cmptd_count", cm_cnt, 1);
        check("calib_no_app_activity", en_cnt, 0);

        // Write vectors with both readies high
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_vld = 1'b1; cmd_proc = 1'b1; addr_proc = wv[i].addr; data_proc_o = wv[i].data;
            blen_proc = 8'h5A;
            step();
            cmd_vld = 1'b0; addr_proc = 32'h0; data_proc_o = 32'h0;
            check("wr_state", tg_state, 8'h04);
            check("wr_app_en", app_en, 1'b1);
            check("wr_wren", app_wdf_wren, 1'b1);
            check("wr_end", app_wdf_end, 1'b1);
            check("wr_app_cmd", app_cmd, 3'b000);
            check("wr_app_addr", app_addr, wv[i].exp_app_addr);
            check("wr_mask", app_wdf_mask, wv[i].exp_mask);
            check("wr_data", app_wdf_data, {4{wv[i].data}});
            step();
            check("wr_done_state", tg_state, 8'h80);
            check("wr_done_cmptd", cmd_cmptd, 1'b1);
            check("wr_done_app_en", app_en, 1'b0);
            check("wr_done_wren", app_wdf_wren, 1'b0);
            step();
            check("wr_back_idle", tg_state, 8'h02);
            check("wr_idle_cmptd", cmd_cmptd, 1'b0);
        end

        // Write with data channel stalled for 5 cycles
        app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        cmd_vld = 1'b1; cmd_proc = 1'b1; addr_proc = 32'h24; data_proc_o = 32'hC0FF_EE00;
        en_cnt = 0; wren_cnt = 0; done_cnt = 0; cm_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            cmd_vld = 1'b0;
            en_cnt   += int'(app_en);
            wren_cnt += int'(app_wdf_wren);
            done_cnt += int'(tg_state == 8'h80);
            cm_cnt   += int'(cmd_cmptd);
            if (c == 5) app_wdf_rdy = 1'b1;
        end
        check("wstall_app_en_cycles", en_cnt, 1);
        check("wstall_wren_cycles", wren_cnt, 6);
        check("wstall_done_count", done_cnt, 1);
        check("wstall_cmptd_count", cm_cnt, 1);
        check("wstall_idle", tg_state, 8'h02);

        // Stray read data in IDLE
        app_rd_data = {4{32'hFFFF_FFFF}}; app_rd_data_valid = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
        check("stray_rvld", rdata_sig_vld, 1'b0);
        step();
        check("stray_rvld_late", rdata_sig_vld, 1'b0);
        check("stray_rdata", data_proc_i, 32'h0);

        // Four-beat read from 0x1C
        app_rdy = 1'b1;
        cmd_vld = 1'b1; cmd_proc = 1'b0; addr_proc = 32'h1C; blen_proc = 8'd3;
        step();
        cmd_vld = 1'b0;
        rv_cnt = 0; cm_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            check("rd_cmd_state", tg_state, 8'h20);
            check("rd_app_en", app_en, 1'b1);
            check("rd_app_cmd", app_cmd, 3'b001);
            check("rd_app_addr", app_addr, rv[b].exp_app_addr);
            if (b == 2) begin
                app_rdy = 1'b0;
                step();
                check("rd_cmd_hold_en", app_en, 1'b1);
                check("rd_cmd_hold_state", tg_state, 8'h20);
                app_rdy = 1'b1;
            end
            step();
            check("rd_data_state", tg_state, 8'h40);
            check("rd_data_app_en", app_en, 1'b0);
            for (int g = 0; g < b; g++) begin
                step();
                rv_cnt += int'(rdata_sig_vld);
            end
            base_w = 32'hB000_0000 | (32'(b) << 4);
            app_rd_data = {base_w | 32'd3, base_w | 32'd2, base_w | 32'd1, base_w};
            app_rd_data_valid = 1'b1;
            step();
            app_rd_data_valid = 1'b0; app_rd_data = 128'h0;
            rv_cnt += int'(rdata_sig_vld);
            cm_cnt += int'(cmd_cmptd);
            check("rd_word", data_proc_i, rv[b].exp_word);
            check("rd_next_state", tg_state, (b == 3) ? 8'h80 : 8'h20);
        end
        step();
        cm_cnt += int'(cmd_cmptd);
        rv_cnt += int'(rdata_sig_vld);
        check("rd_rvld_count", rv_cnt, 4);
        check("rd_cmptd_count", cm_cnt, 1);
        check("rd_back_idle", tg_state, 8'h02);

        // 256-beat read crossing the 4 GiB wrap
        cmd_vld = 1'b1; cmd_proc = 1'b0; addr_proc = 32'hFFFF_FFF8; blen_proc = 8'hFF;
        step();
        cmd_vld = 1'b0;
        nrd = 0; rv_cnt = 0; cm_cnt = 0; done = 1'b0; aa0 = 28'h0; aa2 = 28'h123_4567;
        for (int t = 0; t < 2000 && !done; t++) begin
            if (app_en) begin
                if (nrd == 0) aa0 = app_addr;
                if (nrd == 2) aa2 = app_addr;
                nrd++;
            end
            rv_cnt += int'(rdata_sig_vld);
            cm_cnt += int'(cmd_cmptd);
            if (cmd_cmptd) done = 1'b1;
            app_rd_data_valid = (tg_state == 8'h40);
            app_rd_data = {4{32'(t)}};
            if (!done) step();
        end
        app_rd_data_valid = 1'b0;
        check("b256_completed", done, 1'b1);
        check("b256_reads", nrd, 256);
        check("b256_rvld", rv_cnt, 256);
        check("b256_cmptd", cm_cnt, 1);
        check("b256_first_addr", aa0, 28'hFFF_FFF8);
        check("b256_wrapped_addr", aa2, 28'h000_0000);
        step();
        check("b256_idle", tg_state, 8'h02);

        // Read whose data never returns
        cmd_vld = 1'b1; cmd_proc = 1'b0; addr_proc = 32'h80; blen_proc = 8'd0;
        step();
        cmd_vld = 1'b0;
        step();
        check("nodata_rd_state", tg_state, 8'h40);
`ifdef TG_RD_TIMEOUT_EN
        n = 0; got = 1'b0;
        for (int t = 0; t < 1100 && !got; t++) begin
            step();
            n++;
            if (rdata_sig_vld) got = 1'b1;
        end
        check("to_fired", got, 1'b1);
        check("to_latency", n, 1024);
        check("to_word", data_proc_i, 32'hDEAD_BEEF);
        check("to_err", err_timeout, 1'b1);
        check("to_done", tg_state, 8'h80);
        check("to_cmptd", cmd_cmptd, 1'b1);
        step();
        check("to_idle", tg_state, 8'h02);
        check("to_err_sticky", err_timeout, 1'b1);
`else
        stuck = 1'b1;
        for (int t = 0; t < 1100; t++) begin
            step();
            if (tg_state != 8'h40 || rdata_sig_vld || err_timeout) stuck = 1'b0;
        end
        check("nodata_waits", stuck, 1'b1);
        check("nodata_err", err_timeout, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step(); step();
        check("nodata_recover_idle", tg_state, 8'h02);
`endif

        // Reset in RD_DATA mid-burst
        app_rdy = 1'b1;
        cmd_vld = 1'b1; cmd_proc = 1'b0; addr_proc = 32'h40; blen_proc = 8'd7;
        step();
        cmd_vld = 1'b0;
        step();
        check("rr_rd_data", tg_state, 8'h40);
        app_rd_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        app_rd_data_valid = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
        check("rr_first_word", data_proc_i, 32'h1111_1111);
        step();
        check("rr_second_rd_data", tg_state, 8'h40);
        #2;
        reset = 1'b1;
        #1;
        check("rr_state", tg_state, 8'h01);
        check("rr_app_en", app_en, 1'b0);
        check("rr_wren", app_wdf_wren, 1'b0);
        check("rr_rdata", data_proc_i, 32'h0);
        check("rr_rvld", rdata_sig_vld, 1'b0);
        check("rr_cmptd", cmd_cmptd, 1'b0);
        check("rr_app_addr", app_addr, 28'h0);
        app_rd_data_valid = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 1) reset = 1'b0;
            rv_cnt += int'(rdata_sig_vld);
        end
        app_rd_data_valid = 1'b0;
        step();
        rv_cnt += int'(rdata_sig_vld);
        check("rr_late_data_dropped", rv_cnt, 0);
        check("rr_back_idle", tg_state, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
